// File: rtl/rsign_para_loader_if.sv
// Threshold write channel into the binarizer parameter loader.
// A word transfers on any rising edge where wr_valid and wr_ready are both high.
interface rsign_para_loader_if;
  logic               wr_valid;
  logic signed [15:0] wr_data;
  logic               wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/rsign_para_loader.sv
// Loads FM_DEPTH signed thresholds into registers that feed the binarizer's para_in.
// mode_out tells the binarizer whether it is loading parameters (0) or calculating (1).
//
// state | meaning
// IDLE  | waiting for start; para_out holds its current contents
// LOAD  | accepting threshold words, one para_out entry per accepted word
// RUN   | all entries written, binarizer in calculate mode
module rsign_para_loader #(
  parameter int FM_DEPTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clear,
  rsign_para_loader_if.slave wr,
  output logic signed [15:0] para_out [FM_DEPTH],
  output logic               mode_out,
  output logic               load_done,
  output logic               busy
);

  localparam int CW = (FM_DEPTH > 1) ? $clog2(FM_DEPTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // clear is only honoured in RUN, and wins over start there
  always_comb begin
    state_nxt   = state;
    wr.wr_ready = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        wr.wr_ready = 1'b1;
        accept      = wr.wr_valid;
        if (wr.wr_valid && (cnt == LAST_IDX)) state_nxt = RUN;
      end
      RUN: begin
        if (clear)      state_nxt = IDLE;
        else if (start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      mode_out  <= 1'b0;
      load_done <= 1'b0;
      for (int i = 0; i < FM_DEPTH; i++) para_out[i] <= '0;
    end else begin
      mode_out  <= (state_nxt == RUN);
      load_done <= (state == LOAD) && (state_nxt == RUN);
      if ((state != LOAD) && (state_nxt == LOAD)) begin
        cnt <= '0;
      end else if (accept) begin
        para_out[cnt] <= wr.wr_data;
        cnt           <= (cnt == LAST_IDX) ? '0 : cnt + CW'(1);
      end
    end
  end

  assign busy = (state == LOAD);

endmodule

// File: tb/tb_rsign_para_loader.sv
// Scenario bench for rsign_para_loader with FM_DEPTH=4; accepted words go to a
// queue of expected (index, value) pairs and are checked when para_out updates.
module tb_rsign_para_loader;
  localparam int D = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               clear;
  logic signed [15:0] para_out [D];
  logic               mode_out;
  logic               load_done;
  logic               busy;

  rsign_para_loader_if wif ();

  rsign_para_loader #(.FM_DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .clear     (clear),
    .wr        (wif),
    .para_out  (para_out),
    .mode_out  (mode_out),
    .load_done (load_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 idx;
    logic signed [15:0] val;
  } exp_t;

  exp_t               exp_q [$];
  logic signed [15:0] model [D];
  int                 model_idx;
  int                 n_cmp = 0;
  int                 n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // stimulus only: offer one word, record where it must land
  task automatic offer(input logic signed [15:0] v);
    exp_t e;
    wif.wr_valid = 1'b1;
    wif.wr_data  = v;
    e.idx = model_idx;
    e.val = v;
    exp_q.push_back(e);
    model[model_idx] = v;
    model_idx = (model_idx + 1) % D;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    model_idx = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; clear = 1'b0;
    wif.wr_valid = 1'b1; wif.wr_data = 16'sd77;
    step(); step();
    n_cmp++; if (wif.wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 0", wif.wr_ready); end
    n_cmp++; if (mode_out !== 1'b0) begin n_fail++; $display("FAIL reset_mode: got %b want 0", mode_out); end
    n_cmp++; if (load_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_flags: load_done %b busy %b want 0 0", load_done, busy); end
    for (int i = 0; i < D; i++) begin
      model[i] = 16'sd0;
      n_cmp++; if (para_out[i] !== 16'sd0) begin n_fail++; $display("FAIL reset_para[%0d]: got %0d want 0", i, para_out[i]); end
    end
    wif.wr_valid = 1'b0;
    rst = 1'b0;
    step();
    n_cmp++; if (wif.wr_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: wr_ready %b busy %b want 0 0", wif.wr_ready, busy); end
  endtask

  task automatic test_full_load();
    logic signed [15:0] words [D];
    exp_t e;
    words[0] = 16'sd10; words[1] = -16'sd5; words[2] = 16'sd32767; words[3] = -16'sd32768;
    do_start();
    n_cmp++; if (busy !== 1'b1 || wif.wr_ready !== 1'b1 || mode_out !== 1'b0) begin n_fail++; $display("FAIL load_entry: busy %b ready %b mode %b want 1 1 0", busy, wif.wr_ready, mode_out); end
    for (int k = 0; k < D; k++) begin
      offer(words[k]);
      step();
      e = exp_q.pop_front();
      n_cmp++; if (para_out[e.idx] !== e.val) begin n_fail++; $display("FAIL full_word[%0d]: got %0d want %0d", e.idx, para_out[e.idx], e.val); end
      if (k < D - 1) begin
        n_cmp++; if (mode_out !== 1'b0 || load_done !== 1'b0) begin n_fail++; $display("FAIL full_early_run k=%0d: mode %b done %b want 0 0", k, mode_out, load_done); end
      end
    end
    wif.wr_valid = 1'b0;
    n_cmp++; if (mode_out !== 1'b1 || load_done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL full_run_entry: mode %b done %b busy %b want 1 1 0", mode_out, load_done, busy); end
    step();
    n_cmp++; if (load_done !== 1'b0 || mode_out !== 1'b1 || wif.wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_done_pulse: done %b mode %b ready %b want 0 1 0", load_done, mode_out, wif.wr_ready); end
    for (int i = 0; i < D; i++) begin
      n_cmp++; if (para_out[i] !== model[i]) begin n_fail++; $display("FAIL full_para[%0d]: got %0d want %0d", i, para_out[i], model[i]); end
    end
  endtask

  task automatic test_reload();
    exp_t e;
    do_start();
    n_cmp++; if (mode_out !== 1'b0 || busy !== 1'b1 || load_done !== 1'b0) begin n_fail++; $display("FAIL reload_entry: mode %b busy %b done %b want 0 1 0", mode_out, busy, load_done); end
    offer(16'sd100);
    step();
    e = exp_q.pop_front();
    for (int i = 0; i < D; i++) begin
      n_cmp++; if (para_out[i] !== model[i]) begin n_fail++; $display("FAIL reload_para[%0d]: got %0d want %0d", i, para_out[i], model[i]); end
    end
    n_cmp++; if (e.idx != 0 || para_out[0] !== 16'sd100) begin n_fail++; $display("FAIL reload_first_idx: idx %0d para0 %0d want 0 100", e.idx, para_out[0]); end
    for (int k = 1; k < D; k++) begin
      offer(16'(200 + k));
      step();
      e = exp_q.pop_front();
      n_cmp++; if (para_out[e.idx] !== e.val) begin n_fail++; $display("FAIL reload_word[%0d]: got %0d want %0d", e.idx, para_out[e.idx], e.val); end
    end
    wif.wr_valid = 1'b0;
    n_cmp++; if (mode_out !== 1'b1 || load_done !== 1'b1) begin n_fail++; $display("FAIL reload_run: mode %b done %b want 1 1", mode_out, load_done); end
    step();
  endtask

  task automatic test_stalls();
    logic pat [7];
    int   acc;
    exp_t e;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_cmp++; if (mode_out !== 1'b0 || wif.wr_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL clear_to_idle: mode %b ready %b busy %b want 0 0 0", mode_out, wif.wr_ready, busy); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_in_idle: busy %b want 0", busy); end
    do_start();
    acc = 0;
    for (int c = 0; c < 7; c++) begin
      if (pat[c]) begin
        offer(16'(-1000 - c));
      end else begin
        wif.wr_valid = 1'b0;
        wif.wr_data  = 16'sh5A5A;
      end
      step();
      if (pat[c]) begin
        acc++;
        e = exp_q.pop_front();
        n_cmp++; if (para_out[e.idx] !== e.val) begin n_fail++; $display("FAIL stall_word[%0d]: got %0d want %0d", e.idx, para_out[e.idx], e.val); end
      end
      n_cmp++; if (mode_out !== (acc == D)) begin n_fail++; $display("FAIL stall_mode c=%0d: got %b want %b", c, mode_out, acc == D); end
    end
    wif.wr_valid = 1'b0;
    for (int i = 0; i < D; i++) begin
      n_cmp++; if (para_out[i] !== model[i]) begin n_fail++; $display("FAIL stall_para[%0d]: got %0d want %0d", i, para_out[i], model[i]); end
    end
    step();
  endtask

  task automatic test_reset_mid_load();
    exp_t e;
    do_start();
    offer(16'sd11); step(); void'(exp_q.pop_front());
    offer(16'sd22); step(); void'(exp_q.pop_front());
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (mode_out !== 1'b0 || wif.wr_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: mode %b ready %b busy %b want 0 0 0", mode_out, wif.wr_ready, busy); end
    for (int i = 0; i < D; i++) begin
      model[i] = 16'sd0;
      n_cmp++; if (para_out[i] !== 16'sd0) begin n_fail++; $display("FAIL midrst_para[%0d]: got %0d want 0", i, para_out[i]); end
    end
    step();
    rst = 1'b0;
    step(); step();
    n_cmp++; if (para_out[0] !== 16'sd0 || para_out[2] !== 16'sd0 || wif.wr_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_no_start: p0 %0d p2 %0d ready %b want 0 0 0", para_out[0], para_out[2], wif.wr_ready); end
    wif.wr_valid = 1'b0;
    do_start();
    for (int k = 0; k < D; k++) begin
      offer(16'(-7 * (k + 1)));
      step();
      e = exp_q.pop_front();
      n_cmp++; if (para_out[e.idx] !== e.val) begin n_fail++; $display("FAIL midrst_reload[%0d]: got %0d want %0d", e.idx, para_out[e.idx], e.val); end
    end
    wif.wr_valid = 1'b0;
    n_cmp++; if (mode_out !== 1'b1 || load_done !== 1'b1) begin n_fail++; $display("FAIL midrst_run: mode %b done %b want 1 1", mode_out, load_done); end
    step();
  endtask

  task automatic test_priority();
    exp_t e;
    start = 1'b1; clear = 1'b1;
    step();
    start = 1'b0; clear = 1'b0;
    n_cmp++; if (mode_out !== 1'b0 || busy !== 1'b0 || wif.wr_ready !== 1'b0 || load_done !== 1'b0) begin n_fail++; $display("FAIL prio_idle: mode %b busy %b ready %b done %b want 0 0 0 0", mode_out, busy, wif.wr_ready, load_done); end
    for (int i = 0; i < D; i++) begin
      n_cmp++; if (para_out[i] !== model[i]) begin n_fail++; $display("FAIL prio_para[%0d]: got %0d want %0d", i, para_out[i], model[i]); end
    end
    do_start();
    for (int k = 0; k < D; k++) begin
      start = (k == 1);
      clear = (k == 2);
      offer(16'(300 + k));
      step();
      e = exp_q.pop_front();
      n_cmp++; if (para_out[e.idx] !== e.val) begin n_fail++; $display("FAIL prio_word[%0d]: got %0d want %0d", e.idx, para_out[e.idx], e.val); end
    end
    start = 1'b0; clear = 1'b0; wif.wr_valid = 1'b0;
    n_cmp++; if (mode_out !== 1'b1 || load_done !== 1'b1) begin n_fail++; $display("FAIL prio_run: mode %b done %b want 1 1", mode_out, load_done); end
    for (int i = 0; i < D; i++) begin
      n_cmp++; if (para_out[i] !== model[i]) begin n_fail++; $display("FAIL prio_final[%0d]: got %0d want %0d", i, para_out[i], model[i]); end
    end
    step();
  endtask

  initial begin
    model_idx = 0;
    wif.wr_valid = 1'b0;
    wif.wr_data  = 16'sd0;
    test_reset();
    test_full_load();
    test_reload();
    test_stalls();
    test_reset_mid_load();
    test_priority();
    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
